// File: rtl/cbus_rr_scheduler_pkg.sv
// Shared cbus types for the request scheduler: request/response structs,
// burst length and transfer size encodings, and the scheduler state enum.
package cbus_rr_scheduler_pkg;

    localparam int CBUS_AW = 32;
    localparam int CBUS_DW = 32;
    localparam int CBUS_SW = CBUS_DW / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_e;

    // len holds beats-minus-one
    typedef enum logic [3:0] {
        MLEN1 = 4'd0,
        MLEN2 = 4'd1,
        MLEN4 = 4'd3,
        MLEN8 = 4'd7
    } mlen_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [CBUS_AW-1:0] addr;
        logic [CBUS_DW-1:0] data;
        logic [CBUS_SW-1:0] strobe;
        msize_e             size;
        mlen_e              len;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CBUS_DW-1:0] data;
    } cbus_resp_t;

    // Number of beats a burst of the given length carries (5 bits so len=15 would not wrap)
    function automatic logic [4:0] beats_expected(input mlen_e len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/cbus_rr_scheduler_picker.sv
// Combinational winner selection: scans the valid vector starting one
// position after ptr_i (modulo NUM_REQ) and returns the first set entry.
// Passing ptr_i = NUM_REQ-1 turns this into lowest-index-first priority.
module cbus_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         ptr_i,
    output logic               found_o,
    output logic [1:0]         idx_o
);

    logic [3:0] valid_pad;
    logic [1:0] cand;
    logic       hit;
    logic [1:0] win;

    // Rotating first-set search over at most four requesters
    always_comb begin
        valid_pad                = '0;
        valid_pad[NUM_REQ-1:0]   = valid_i;
        cand                     = '0;
        hit                      = 1'b0;
        win                      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(ptr_i) + k) % NUM_REQ);
            if (!hit && valid_pad[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    assign found_o = hit;
    assign idx_o   = win;

endmodule

// File: rtl/cbus_rr_scheduler.sv
// cbus request scheduler: grants one of NUM_REQ (2..4) upstream requesters
// access to the shared memory bus for one whole burst, routes the bus
// response back to the granted requester and flags beat-count protocol
// errors (sticky until reset).
// Build option: CBUS_RR_SCHED_RR_EN selects round-robin arbitration;
// without it the lowest requester index always wins.
//
// state  | meaning
// S_IDLE | no grant; outputs quiet; picks a winner when any request is valid
// S_BUSY | burst in flight for grant_idx; request/response passed through
module cbus_rr_scheduler
    import cbus_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       busy,
    output logic [1:0] grant_idx,
    output logic       proto_err
);

    sched_state_e state_q, state_d;
    logic [1:0]   grant_idx_q, grant_idx_d;
    logic [3:0]   beat_cnt_q, beat_cnt_d;
    logic         proto_err_q, proto_err_d;

    logic [NUM_REQ-1:0] req_valid;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [1:0]         pick_ptr;
    cbus_req_t          gnt_req;
    logic [4:0]         beat_num;
    logic [4:0]         beat_exp;

    // Collect the valid bits for the picker
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

`ifdef CBUS_RR_SCHED_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Pointer follows the most recent winner so the search starts just past it
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_IDLE && pick_found) begin
            rr_ptr_d = pick_idx;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= 2'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pick_ptr = rr_ptr_q;
`else
    // Fixed start point: search always begins at requester 0
    assign pick_ptr = 2'(NUM_REQ - 1);
`endif

    cbus_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Output muxing: pass the granted request out and route the response back
    always_comb begin
        oreq    = '0;
        gnt_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end
        if (state_q == S_BUSY) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_idx_q == 2'(i)) begin
                    gnt_req   = ireqs[i];
                    iresps[i] = oresp;
                end
            end
            oreq = gnt_req;
        end
    end

    assign beat_num = {1'b0, beat_cnt_q} + 5'd1;
    assign beat_exp = beats_expected(gnt_req.len);

    // Next-state, grant, beat counter and error flag
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d  = beat_cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            S_IDLE: begin
                beat_cnt_d  = '0;
                grant_idx_d = '0;
                if (pick_found) begin
                    state_d     = S_BUSY;
                    grant_idx_d = pick_idx;
                end
            end
            S_BUSY: begin
                if (!gnt_req.valid) begin
                    // requester withdrew mid-burst
                    state_d     = S_IDLE;
                    grant_idx_d = '0;
                    beat_cnt_d  = '0;
                    proto_err_d = 1'b1;
                end else if (oresp.ready) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (oresp.last) begin
                        if (beat_num != beat_exp) begin
                            proto_err_d = 1'b1;
                        end
                        state_d     = S_IDLE;
                        grant_idx_d = '0;
                        beat_cnt_d  = '0;
                    end else if (beat_num > beat_exp) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                grant_idx_d = '0;
                beat_cnt_d  = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign grant_idx = grant_idx_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cbus_rr_scheduler.sv
// Directed bench for cbus_rr_scheduler (NUM_REQ = 2). Response routing and
// grant order are checked through scoreboard queues filled as stimulus is
// driven. Expected grant order follows CBUS_RR_SCHED_RR_EN.
module tb_cbus_rr_scheduler;
    import cbus_rr_scheduler_pkg::*;

    localparam int NUM_REQ = 2;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [NUM_REQ];
    cbus_resp_t iresps [NUM_REQ];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [1:0] grant_idx;
    logic       proto_err;

    typedef struct {
        int         idx;
        cbus_resp_t resp;
    } resp_exp_t;

    resp_exp_t resp_q[$];
    int        grant_q[$];
    int        total  = 0;
    int        passed = 0;
    int        failed = 0;

    cbus_rr_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) ireqs[i] = '0;
        oresp = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drive one response beat; expectation queued, then compared once routed
    task automatic drive_beat(input int g, input logic rdy, input logic lst, input logic [31:0] d);
        resp_exp_t  e;
        cbus_resp_t z;
        z            = '0;
        oresp.ready  = rdy;
        oresp.last   = lst;
        oresp.data   = d;
        e.idx        = g;
        e.resp.ready = rdy;
        e.resp.last  = lst;
        e.resp.data  = d;
        resp_q.push_back(e);
        #1;
        e = resp_q.pop_front();
        for (int i = 0; i < NUM_REQ; i++) begin
            check($sformatf("iresps[%0d]", i), 128'(iresps[i]),
                  (i == e.idx) ? 128'(e.resp) : 128'(z));
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!busy && n < 8);
        check("wait_busy", 128'(busy), 128'(1'b1));
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input mlen_e len, input logic wr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.data     = ~addr;
        r.strobe   = 4'hF;
        r.size     = MSIZE4;
        r.len      = len;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cbus_req_t  r1;
        cbus_req_t  z_req;
        cbus_resp_t z_resp;
        int         n;
        int         g;
        z_req  = '0;
        z_resp = '0;

        // reset state
        do_reset();
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_grant", 128'(grant_idx), 128'(2'd0));
        check("rst_perr", 128'(proto_err), 128'(1'b0));
        check("rst_oreq", 128'(oreq), 128'(z_req));

        // single requester 1, MLEN4 read
        r1       = mk_req(32'h1000_0040, MLEN4, 1'b0);
        ireqs[1] = r1;
        #1;
        check("idle_oreq_valid", 128'(oreq.valid), 128'(1'b0));
        check("idle_iresp1", 128'(iresps[1]), 128'(z_resp));
        step();
        check("s1_busy", 128'(busy), 128'(1'b1));
        check("s1_grant", 128'(grant_idx), 128'(2'd1));
        check("s1_oreq", 128'(oreq), 128'(r1));
        for (int b = 1; b <= 4; b++) begin
            drive_beat(1, 1'b1, (b == 4), 32'hA000_0000 + 32'(b));
            step();
            if (b < 4) check($sformatf("s1_busy_b%0d", b), 128'(busy), 128'(1'b1));
        end
        check("s1_end_busy", 128'(busy), 128'(1'b0));
        check("s1_end_grant", 128'(grant_idx), 128'(2'd0));
        check("s1_end_perr", 128'(proto_err), 128'(1'b0));
        check("s1_end_oreq_valid", 128'(oreq.valid), 128'(1'b0));
        ireqs[1] = '0;
        oresp    = '0;

        // contention, both requesters valid with MLEN1
        do_reset();
        ireqs[0] = mk_req(32'h2000_0000, MLEN1, 1'b1);
        ireqs[1] = mk_req(32'h3000_0000, MLEN1, 1'b0);
`ifdef CBUS_RR_SCHED_RR_EN
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
`else
        grant_q.push_back(0); grant_q.push_back(0); grant_q.push_back(0); grant_q.push_back(0);
`endif
        for (int k = 0; k < 4; k++) begin
            wait_busy(n);
            check($sformatf("cont_gap%0d", k), 128'(n), 128'(1));
            g = grant_q.pop_front();
            check($sformatf("cont_grant%0d", k), 128'(grant_idx), 128'(g));
            check($sformatf("cont_addr%0d", k), 128'(oreq.addr), 128'(ireqs[g].addr));
            drive_beat(g, 1'b1, 1'b1, 32'hC000_0000 + 32'(k));
            step();
            oresp = '0;
            check($sformatf("cont_idle%0d", k), 128'(busy), 128'(1'b0));
        end

        // last on beat 2 of an MLEN4 burst
        do_reset();
        ireqs[0] = mk_req(32'h4000_0000, MLEN4, 1'b0);
        step();
        check("be_busy", 128'(busy), 128'(1'b1));
        drive_beat(0, 1'b1, 1'b0, 32'h11);
        step();
        check("be_perr_b1", 128'(proto_err), 128'(1'b0));
        drive_beat(0, 1'b1, 1'b1, 32'h22);
        step();
        check("be_perr_set", 128'(proto_err), 128'(1'b1));
        check("be_idle", 128'(busy), 128'(1'b0));
        ireqs[0] = '0;
        oresp    = '0;
        step(); step(); step();
        check("be_perr_held", 128'(proto_err), 128'(1'b1));

        // ready past the expected count without last
        do_reset();
        check("ov_perr_rst", 128'(proto_err), 128'(1'b0));
        ireqs[0] = mk_req(32'h5000_0000, MLEN1, 1'b0);
        step();
        drive_beat(0, 1'b1, 1'b0, 32'h33);
        step();
        check("ov_perr_b1", 128'(proto_err), 128'(1'b0));
        drive_beat(0, 1'b1, 1'b0, 32'h44);
        step();
        check("ov_perr_b2", 128'(proto_err), 128'(1'b1));
        drive_beat(0, 1'b1, 1'b1, 32'h55);
        step();
        check("ov_idle", 128'(busy), 128'(1'b0));
        ireqs[0] = '0;
        oresp    = '0;

        // abort at beat 2 of 4, other requester waiting
        do_reset();
        ireqs[0] = mk_req(32'h6000_0000, MLEN4, 1'b0);
        ireqs[1] = mk_req(32'h7000_0000, MLEN4, 1'b1);
        step();
        check("ab_grant0", 128'(grant_idx), 128'(2'd0));
        drive_beat(0, 1'b1, 1'b0, 32'h66);
        step();
        ireqs[0].valid = 1'b0;
        oresp          = '0;
        #1;
        check("ab_oreq_valid", 128'(oreq.valid), 128'(1'b0));
        step();
        check("ab_idle", 128'(busy), 128'(1'b0));
        check("ab_perr", 128'(proto_err), 128'(1'b1));
        step();
        check("ab_busy1", 128'(busy), 128'(1'b1));
        check("ab_grant1", 128'(grant_idx), 128'(2'd1));

        // reset asserted at beat 3 of the burst to requester 1
        ireqs[0] = mk_req(32'h6000_0100, MLEN4, 1'b0);
        drive_beat(1, 1'b1, 1'b0, 32'h71);
        step();
        drive_beat(1, 1'b1, 1'b0, 32'h72);
        step();
        reset = 1'b1;
        drive_beat(1, 1'b1, 1'b0, 32'h73);
        step();
        check("rm_oreq_valid", 128'(oreq.valid), 128'(1'b0));
        check("rm_grant", 128'(grant_idx), 128'(2'd0));
        check("rm_perr", 128'(proto_err), 128'(1'b0));
        check("rm_busy", 128'(busy), 128'(1'b0));
        check("rm_iresp1", 128'(iresps[1]), 128'(z_resp));
        reset = 1'b0;
        oresp = '0;
        step();
        check("rm_post_busy", 128'(busy), 128'(1'b1));
        check("rm_post_grant", 128'(grant_idx), 128'(2'd0));

        for (int i = 0; i < NUM_REQ; i++) ireqs[i] = '0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
